// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if
//   Groups the upstream (sum in) and downstream (batch total out) handshakes
//   of sum_accumulator.
//
//   Handshake rule for both channels: a transfer happens on a rising clk edge
//   where valid and ready are both high. A producer holds valid and its data
//   stable until that edge. The consumer may raise ready before valid.
//
//   Signals:
//     in_valid / in_ready / in_value                : upstream sum channel
//     out_valid / out_ready / out_value / out_overflow : batch total channel
//   Modports:
//     master : the surrounding system (drives inputs, observes outputs)
//     slave  : the accumulator itself
interface sum_accumulator_if #(
  parameter int IN_WIDTH  = 9,
  parameter int ACC_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_value;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_value;
  logic                 out_overflow;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_value, out_overflow
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_value, out_overflow
  );
endinterface

// File: rtl/sum_accumulator.sv
// sum_accumulator
//   Unsigned batch accumulator placed after the parameterized adder. It adds
//   COUNT accepted sums into an ACC_WIDTH register, then presents the batch
//   total on a held valid/ready port. An overflow anywhere in the batch is
//   flagged on out_overflow.
//
//   Optional build macro: SUM_ACCUMULATOR_SATURATE_EN
//     defined   : accumulator clamps to 2^ACC_WIDTH-1 once the batch overflows
//     undefined : accumulator wraps modulo 2^ACC_WIDTH
//
//   Parameters: IN_WIDTH (input sum width), ACC_WIDTH (>= IN_WIDTH),
//               COUNT (samples per batch, >= 1)
//   Ports:
//     clk       : single clock, rising edge
//     rst       : synchronous, active-high reset
//     bus       : sum_accumulator_if.slave (in_* and out_* handshakes)
//     fsm_state : debug view of the FSM (0 = ACCUM, 1 = HOLD)
module sum_accumulator #(
  parameter int IN_WIDTH  = 9,
  parameter int ACC_WIDTH = 16,
  parameter int COUNT     = 4
) (
  input  logic              clk,
  input  logic              rst,
  sum_accumulator_if.slave  bus,
  output logic              fsm_state
);
  // Wide enough to hold the value COUNT itself.
  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     count;
  logic                 ovf;
  logic [ACC_WIDTH-1:0] out_value_q;
  logic                 out_overflow_q;

  logic                 accept;
  logic                 last_sample;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 carry;
  logic [ACC_WIDTH-1:0] next_acc;
  logic                 next_ovf;

  // in_ready is a pure decode of the state register, so out_ready never
  // reaches in_ready combinationally; this costs one idle input cycle after
  // every output handshake.
  assign bus.in_ready     = (state == ACCUM);
  assign bus.out_valid    = (state == HOLD);
  assign bus.out_value    = out_value_q;
  assign bus.out_overflow = out_overflow_q;
  assign fsm_state        = (state == HOLD);

  assign accept      = bus.in_valid & (state == ACCUM);
  assign last_sample = (count == CNT_W'(COUNT - 1));

  // One extra bit catches the carry out of the accumulator.
  assign sum_ext = {1'b0, acc} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, bus.in_value};
  assign carry   = sum_ext[ACC_WIDTH];

  always_comb begin
    next_ovf = ovf | carry;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    // Once the batch has overflowed it stays pinned at the maximum.
    next_acc = next_ovf ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
`else
    next_acc = sum_ext[ACC_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ACCUM;
      acc            <= '0;
      count          <= '0;
      ovf            <= 1'b0;
      out_value_q    <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc   <= next_acc;
            count <= count + CNT_W'(1);
            ovf   <= next_ovf;
            if (last_sample) begin
              // Register the total including this final sample.
              out_value_q    <= next_acc;
              out_overflow_q <= next_ovf;
              state          <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator
//   Bench for sum_accumulator: a COUNT=4 instance driven by directed and
//   random batches, and a COUNT=1 instance with out_ready tied high.
//   Expected totals come from a batch model using plain integer arithmetic.
module tb_sum_accumulator;
  localparam int IN_W    = 9;
  localparam int ACC_W   = 10;
  localparam int CNT     = 4;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic state_a;
  logic state_b;

  sum_accumulator_if #(.IN_WIDTH(IN_W), .ACC_WIDTH(ACC_W)) bus_a ();
  sum_accumulator_if #(.IN_WIDTH(IN_W), .ACC_WIDTH(ACC_W)) bus_b ();

  sum_accumulator #(.IN_WIDTH(IN_W), .ACC_WIDTH(ACC_W), .COUNT(CNT)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_a),
    .fsm_state (state_a)
  );

  sum_accumulator #(.IN_WIDTH(IN_W), .ACC_WIDTH(ACC_W), .COUNT(1)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_b),
    .fsm_state (state_b)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [ACC_W:0] exp_q[$];   // {overflow, value}
  int batch_sum = 0;
  int batch_n   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Batch total from the true (unbounded) sum.
  function automatic logic [ACC_W:0] batch_result(input int total);
    logic             o;
    logic [ACC_W-1:0] v;
    o = (total > ACC_MAX);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    v = o ? ACC_W'(ACC_MAX) : ACC_W'(total);
`else
    v = ACC_W'(total % (ACC_MAX + 1));
`endif
    return {o, v};
  endfunction

  task automatic model_accept(input int v);
    batch_sum += v;
    batch_n++;
    if (batch_n == CNT) begin
      exp_q.push_back(batch_result(batch_sum));
      batch_sum = 0;
      batch_n   = 0;
    end
  endtask

  task automatic model_reset();
    batch_sum = 0;
    batch_n   = 0;
    exp_q.delete();
  endtask

  // ---------------- drivers (inputs change 1 time unit after posedge) ----------------
  task automatic idle_a(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input int v);
    logic accepted;
    accepted = 1'b0;
    bus_a.in_valid = 1'b1;
    bus_a.in_value = IN_W'(v);
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (bus_a.in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    bus_a.in_valid = 1'b0;
    bus_a.in_value = IN_W'($urandom);
    if (accepted) model_accept(v);
    else check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Raise out_ready and compare the handshaken total against the model.
  task automatic collect_a();
    logic           seen;
    logic [ACC_W:0] e;
    seen = 1'b0;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
      return;
    end
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus_a.out_valid) begin
        e = exp_q.pop_front();
        check("out_value", 32'(bus_a.out_value), 32'(e[ACC_W-1:0]));
        check("out_overflow", 32'(bus_a.out_overflow), 32'(e[ACC_W]));
        seen = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus_a.out_ready = 1'b0;
    if (!seen) check("result_timeout", 32'd0, 32'd1);
    else begin
      check("in_ready_after_hs", 32'(bus_a.in_ready), 32'd1);
      check("out_valid_after_hs", 32'(bus_a.out_valid), 32'd0);
    end
  endtask

  task automatic send_b(input int v);
    logic           accepted;
    logic [ACC_W:0] e;
    accepted = 1'b0;
    e = batch_result(v);
    bus_b.in_valid = 1'b1;
    bus_b.in_value = IN_W'(v);
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (bus_b.in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    bus_b.in_valid = 1'b0;
    if (!accepted) begin
      check("b_accept_timeout", 32'd0, 32'd1);
      return;
    end
    check("b_in_ready_low", 32'(bus_b.in_ready), 32'd0);
    check("b_out_valid", 32'(bus_b.out_valid), 32'd1);
    check("b_out_value", 32'(bus_b.out_value), 32'(e[ACC_W-1:0]));
    check("b_out_overflow", 32'(bus_b.out_overflow), 32'(e[ACC_W]));
    @(posedge clk);
    #1;
    check("b_in_ready_back", 32'(bus_b.in_ready), 32'd1);
    check("b_out_valid_done", 32'(bus_b.out_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus_a.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus_a.out_valid), 32'd0);
    check({tag, "_out_value"}, 32'(bus_a.out_value), 32'd0);
    check({tag, "_out_overflow"}, 32'(bus_a.out_overflow), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_a.in_valid  = 1'b0;
    bus_a.in_value  = '0;
    bus_a.out_ready = 1'b0;
    bus_b.in_valid  = 1'b0;
    bus_b.in_value  = '0;
    bus_b.out_ready = 1'b1;
    rst = 1'b1;
    idle_a(2);
    check_reset_outputs("reset");
    check("reset_b_in_ready", 32'(bus_b.in_ready), 32'd1);
    check("reset_b_out_valid", 32'(bus_b.out_valid), 32'd0);
    rst = 1'b0;
    idle_a(1);

    // Basic batch, back-to-back.
    send_a(100);
    send_a(200);
    send_a(300);
    send_a(400);
    check("basic_valid_next_cycle", 32'(bus_a.out_valid), 32'd1);
    collect_a();

    // Overflow batch.
    for (int i = 0; i < 4; i++) send_a(511);
    collect_a();

    // Backpressure with in_valid held high.
    for (int i = 0; i < CNT; i++) send_a($urandom_range(0, 511));
    bus_a.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_a.in_value = IN_W'($urandom);
      @(negedge clk);
      check("bp_out_valid", 32'(bus_a.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus_a.in_ready), 32'd0);
      check("bp_out_value", 32'(bus_a.out_value), 32'(exp_q[0][ACC_W-1:0]));
      @(posedge clk);
      #1;
    end
    collect_a();
    bus_a.in_valid = 1'b0;
    send_a(1);
    send_a(2);
    send_a(3);
    send_a(4);
    collect_a();

    // Gaps between samples.
    send_a(5);
    idle_a(2);
    check("gap_valid_1", 32'(bus_a.out_valid), 32'd0);
    send_a(6);
    idle_a(2);
    check("gap_valid_2", 32'(bus_a.out_valid), 32'd0);
    send_a(7);
    idle_a(2);
    check("gap_valid_3", 32'(bus_a.out_valid), 32'd0);
    send_a(8);
    check("gap_valid_4", 32'(bus_a.out_valid), 32'd1);
    collect_a();

    // Reset mid-batch.
    send_a(50);
    send_a(60);
    rst = 1'b1;
    idle_a(1);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) send_a(1);
    collect_a();

    // Reset while holding a result.
    for (int i = 0; i < CNT; i++) send_a(511);
    check("hold_before_rst", 32'(bus_a.out_valid), 32'd1);
    rst = 1'b1;
    idle_a(1);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    model_reset();

    // Random batches, some with out_ready raised early.
    for (int b = 0; b < 20; b++) begin
      logic early;
      early = 1'($urandom_range(0, 1));
      for (int i = 0; i < CNT; i++) begin
        if (i == CNT - 1 && early) bus_a.out_ready = 1'b1;
        send_a(($urandom_range(0, 2) == 0) ? 511 : $urandom_range(0, 511));
        if (i != CNT - 1) idle_a($urandom_range(0, 2));
      end
      if (!early) idle_a($urandom_range(0, 3));
      collect_a();
    end

    // COUNT=1 instance.
    send_b(7);
    send_b(9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Unsigned batch accumulator that sits directly downstream of the parameterized adder. It consumes the adder's sum output through a valid/ready handshake and adds `COUNT` consecutive sums into a wide register. It then presents the batch total on a held valid/ready output port. Overflow across a batch is flagged, and optionally saturated.

## Interface
- `IN_WIDTH`, 9, width of incoming sum; set to the adder output width, max(WIDTH_1, WIDTH_2)+1
- `ACC_WIDTH`, 16, accumulator/result width; must be >= `IN_WIDTH`
- `COUNT`, 4, samples per batch; must be >= 1

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream sum is valid
- `in_ready`  out  1  block can accept a sum this cycle
- `in_value`  in  IN_WIDTH  unsigned sum from the adder
- `out_valid`  out  1  batch total available
- `out_ready`  in  1  downstream accepts total
- `out_value`  out  ACC_WIDTH  unsigned batch total
- `out_overflow`  out  1  total exceeded 2^ACC_WIDTH-1 during this batch

## Operation
- Two-state FSM: ACCUM and HOLD.
- Reset state: ACCUM. Accumulator = 0, sample count = 0, overflow flag = 0.
- Reset values of outputs: `in_ready`=1, `out_valid`=0, `out_value`=0, `out_overflow`=0.
- ACCUM behaviour:
  - `in_ready`=1 and `out_valid`=0.
  - An accept is `in_valid & in_ready`.
  - On accept, acc <= acc + zero-extended `in_value`, and count <= count+1.
- Overflow: any accept whose true sum exceeds 2^ACC_WIDTH-1 sets the overflow flag. The flag is sticky until the batch is consumed.
- ACCUM -> HOLD on the accept that makes count == `COUNT`. The final sum, including that sample, is registered into `out_value` and `out_overflow`.
- HOLD behaviour:
  - `in_ready`=0 and `out_valid`=1.
  - `out_value` and `out_overflow` are held stable.
- HOLD -> ACCUM on `out_valid & out_ready`. The accumulator, count and flag clear to 0 in the same edge.
- With `COUNT`=1, every accept moves the FSM to HOLD.
- Cycles with `in_valid`=0 leave all state unchanged; gaps inside a batch are allowed.
- `in_value` is ignored when no accept occurs.
- `rst` asserted at any time, including mid-batch or in HOLD, discards the partial batch and any held result, and returns all state to reset values on the next edge.

## Timing
- Accept to accumulate: the sum is updated on the edge of the accept.
- Result latency: `out_valid` rises on the edge of the `COUNT`-th accept, so it is visible the cycle after that accept.
- Throughput: there is no combinational path from `out_ready` to `in_ready`.
  - `in_ready` is a registered-state decode: it is 1 exactly when the FSM is in ACCUM.
  - One idle input cycle follows each output handshake.
  - Maximum rate is `COUNT` samples per `COUNT`+1 cycles.
- `out_ready` may be high before `out_valid`. The handshake completes on the first cycle both are high.
- `out_valid` never deasserts without a handshake or `rst`.

## Configuration
- Macro: `SUM_ACCUMULATOR_SATURATE_EN`.
- Defined: on overflow the accumulator clamps to 2^ACC_WIDTH-1 and stays clamped for the rest of the batch. `out_overflow`=1.
- Undefined: the accumulator wraps modulo 2^ACC_WIDTH. `out_overflow`=1 still reports the wrap.
- All other behaviour is identical in both builds.

## Test plan
- Basic batch (`IN_WIDTH`=9, `ACC_WIDTH`=10, `COUNT`=4): accept 100, 200, 300, 400 back-to-back.
  - `out_value`=1000 and `out_overflow`=0, with `out_valid` high the cycle after the 4th accept.
- Overflow, same parameters: accept 511 four times.
  - Wrap build: `out_value`=1020, `out_overflow`=1.
  - Saturate build: `out_value`=1023, `out_overflow`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after a result, with `in_valid`=1 throughout.
  - `out_value` and `out_valid` stay stable, `in_ready`=0, and no samples are accepted.
  - After `out_ready`=1 for one cycle, the next batch starts from 0.
- Input gaps: feed samples 5, 6, 7, 8 with `in_valid` low 2 cycles between each.
  - `out_value`=26, and `out_valid` does not rise before the 4th accept.
- Reset mid-batch: accept 50 and 60, assert `rst` for 1 cycle, then accept 1, 1, 1, 1.
  - `out_value`=4 and `out_overflow`=0.
  - While `rst` is high, all outputs read their reset values on the following cycle.
- `COUNT`=1: accept 7 then 9 with `out_ready` tied high.
  - Two results, 7 then 9.
  - `in_ready` is low for exactly one cycle after each accept.
